// File: rtl/axis_mem_tx_master.sv
// Walks a memory model and streams its entries as AXI4-Stream beats toward the TX MAC.
// Latency: first beat is valid one cycle after start is sampled; one beat per cycle thereafter.
// Backpressure: the output register advances only on a free slot (!tvalid || tready); otherwise everything holds.
module axis_mem_tx_master #(
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 2048,
    parameter int IFG_CYCLES = 3
) (
    input  logic                    tx_mac_aclk,
    input  logic                    reset_,
    input  logic                    start,
    input  logic [31:0]             start_addr,
    output logic [31:0]             mem_wr_address,
    input  logic [31:0]             mem_axis_wctrl,
    input  logic [DATA_WIDTH-1:0]   mem_axis_wdata,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             frame_cnt,
    output logic                    err_keep
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic [31:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [KW-1:0]         r_tkeep;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_done;
    logic [15:0]           r_frame_cnt;
    logic                  r_err_keep;
    logic [GW-1:0]         r_gap_cnt;

    state_t                w_state_nxt;
    logic [31:0]           w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_tdata_nxt;
    logic [KW-1:0]         w_tkeep_nxt;
    logic                  w_tvalid_nxt;
    logic                  w_tlast_nxt;
    logic                  w_done_nxt;
    logic [15:0]           w_frame_cnt_nxt;
    logic                  w_err_keep_nxt;
    logic [GW-1:0]         w_gap_cnt_nxt;

    logic                  w_slot_free;
    logic                  w_last_hs;
    logic [31:0]           w_addr_inc;
    logic [KW-1:0]         w_ctrl_keep;
    logic                  w_ctrl_vld;
    logic                  w_ctrl_last;
    logic                  w_ctrl_eot;
    logic                  w_keep_bad;
    logic                  w_unused_ctrl;

    assign w_slot_free   = !r_tvalid || m_axis_tready;
    assign w_last_hs     = r_tvalid && m_axis_tready && r_tlast;
    assign w_addr_inc    = (r_addr == 32'(MEM_DEPTH - 1)) ? 32'd0 : r_addr + 32'd1;
    assign w_ctrl_vld    = mem_axis_wctrl[31];
    assign w_ctrl_last   = mem_axis_wctrl[30];
    assign w_ctrl_eot    = mem_axis_wctrl[29];
    assign w_ctrl_keep   = mem_axis_wctrl[KW-1:0];
    // Remaining control bits carry no meaning for this stage.
    assign w_unused_ctrl = ^mem_axis_wctrl;
    // A zero keep is never legal; a partial keep is only legal on the last beat of a frame.
    assign w_keep_bad    = (w_ctrl_keep == '0) || (!w_ctrl_last && (w_ctrl_keep != '1));

    // Next-state and next-output logic for the walk FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_tdata_nxt     = r_tdata;
        w_tkeep_nxt     = r_tkeep;
        w_tvalid_nxt    = r_tvalid;
        w_tlast_nxt     = r_tlast;
        w_done_nxt      = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt + {15'd0, w_last_hs};
        w_err_keep_nxt  = r_err_keep;
        w_gap_cnt_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_addr_nxt      = start_addr;
                    w_frame_cnt_nxt = 16'd0;
                    w_err_keep_nxt  = 1'b0;
                    w_state_nxt     = S_RUN;
                end
            end
            S_RUN: begin
                if (w_slot_free) begin
                    // Any beat in the register has just left (or was never there).
                    w_tvalid_nxt = 1'b0;
                    if (w_ctrl_eot) begin
                        w_state_nxt = S_DRAIN;
                    end else if (!w_ctrl_vld) begin
                        w_addr_nxt = w_addr_inc;
                    end else begin
                        w_tdata_nxt  = mem_axis_wdata;
                        w_tkeep_nxt  = w_ctrl_keep;
                        w_tlast_nxt  = w_ctrl_last;
                        w_tvalid_nxt = 1'b1;
                        w_addr_nxt   = w_addr_inc;
                        if (w_keep_bad) begin
                            w_err_keep_nxt = 1'b1;
                        end
                        if (w_ctrl_last && (IFG_CYCLES > 0)) begin
                            w_state_nxt   = S_GAP;
                            w_gap_cnt_nxt = GW'(IFG_CYCLES);
                        end
                    end
                end
            end
            S_GAP: begin
                // The edge on which the tlast beat handshakes counts as the first gap
                // tick, so the line sees exactly IFG_CYCLES idle cycles before the
                // next beat is loaded.
                if (w_slot_free) begin
                    w_tvalid_nxt = 1'b0;
                    if (r_gap_cnt <= GW'(1)) begin
                        w_gap_cnt_nxt = '0;
                        w_state_nxt   = S_RUN;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - GW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (w_slot_free) begin
                    w_tvalid_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_tvalid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything including any in-flight beat.
    always_ff @(posedge tx_mac_aclk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
            r_err_keep  <= 1'b0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_tdata     <= w_tdata_nxt;
            r_tkeep     <= w_tkeep_nxt;
            r_tvalid    <= w_tvalid_nxt;
            r_tlast     <= w_tlast_nxt;
            r_done      <= w_done_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_err_keep  <= w_err_keep_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
        end
    end

    assign mem_wr_address = r_addr;
    assign m_axis_tdata   = r_tdata;
    assign m_axis_tkeep   = r_tkeep;
    assign m_axis_tvalid  = r_tvalid;
    assign m_axis_tlast   = r_tlast;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign frame_cnt      = r_frame_cnt;
    assign err_keep       = r_err_keep;

endmodule
